anticipator_update: RTL and testbench
=====================================

Name: anticipator_update

Overview:
- Writer side of the 2-bit anticipator table (4096 x 2-bit, combinational read, two write ports).
- Accepts up to two resolved outcomes per cycle and reads the current counters through two table read ports.
- Computes saturating 2-bit counter updates and drives both table write ports.
- Also owns table initialisation: the table has no reset, so this block sweeps every entry after reset or flush.

Parameters:
- ADDR_W, 12, table index width (table depth = 2^ADDR_W)
- CNT_W, 2, counter width
- INIT_VAL, 2'b01, value written by the init sweep (weak not-taken)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  restart init sweep; squashes in-flight updates
- upd0_en  in  1  lane-0 update valid
- upd0_addr  in  ADDR_W  lane-0 table index
- upd0_taken  in  1  lane-0 outcome
- upd1_en  in  1  lane-1 update valid (lane 1 is younger)
- upd1_addr  in  ADDR_W  lane-1 table index
- upd1_taken  in  1  lane-1 outcome
- upd_ready  out  1  updates accepted this cycle (high only in RUN)
- init_busy  out  1  sweep in progress
- rd0_addr  out  ADDR_W  table read address, lane 0
- rd0_data  in  CNT_W  table read data, lane 0 (combinational, same cycle)
- rd1_addr  out  ADDR_W  table read address, lane 1
- rd1_data  in  CNT_W  table read data, lane 1
- wr0_addr  out  ADDR_W  table write address, port 0
- wr0_data  out  CNT_W  table write data, port 0
- wr0_wen  out  1  table write enable, port 0
- wr1_addr  out  ADDR_W  table write address, port 1
- wr1_data  out  CNT_W  table write data, port 1
- wr1_wen  out  1  table write enable, port 1

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous and active-high.
  - The cycle after rst is sampled: state=INIT, sweep idx=0, S1/S2 valids=0, wr*_wen=0, wr*_addr=0, wr*_data=0, upd_ready=0, init_busy=1.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - taken -> +1, saturating at 11.
  - not-taken -> -1, saturating at 00.
  - A write is issued even when the value does not change.
- FSM INIT:
  - Each cycle, register wr0 = {idx,0} and wr1 = {idx,1}, both with data INIT_VAL and wen=1.
  - idx is an (ADDR_W-1)-bit counter; 2048 cycles cover 4096 entries.
  - On idx==2047 go to RUN.
  - upd_ready=0 and init_busy=1 throughout INIT; upd*_en is ignored.
- FSM RUN: upd_ready=1, init_busy=0.
  - flush (any state) -> INIT with idx=0; S1 and S2 are squashed in the same edge, so no update write reaches the table after flush.
  - flush during INIT restarts the sweep from 0.
- Update pipeline in RUN:
  - Edge E0: upd*_en sampled into S1.
  - During S1: rd*_addr = S1 addrs; new values computed combinationally; results registered into S2 at E1.
  - wr* outputs come straight from S2 registers and are valid in the cycle after E1; the table commits at E2.
  - Update latency = 2 edges.
- Forwarding:
  - If an S1 lane addr equals a valid S2 write addr, use the S2 data instead of rd*_data, because the table is not yet updated.
  - S2 port 1 has priority over port 0 if both match.
- Same-cycle same-address (upd0_addr==upd1_addr, both en):
  - Lane 1 uses lane 0's computed result as its old value.
  - wr0_wen=0 and wr1_wen=1 with the combined result.
  - Example: 01 with taken+taken -> 11.
- rd*_addr during INIT or idle: don't-care; drive S1 addr.
- Only one lane enabled: the other port's wen=0.

Decomposition:
- Shared package holds:
  - ADDR_W, CNT_W, INIT_VAL
  - counter encoding constants CNT_SNT/WNT/WT/ST
  - FSM state enum {INIT, RUN}
- One natural sub-module: anticipator_sat_cnt (combinational 2-bit saturating inc/dec), instantiated three times: lane0, lane1, lane1-chained.

Test Plan:
- Reset then release -> init_busy=1 for exactly 2048 cycles; writes cover addrs 0..4095 once each with 01; then upd_ready=1.
- Table[0x123]=01, upd0 taken at 0x123 -> wr0_wen=1, wr0_addr=0x123, wr0_data=10 two edges later; wr1_wen=0.
- Saturation: table[0x010]=11 with upd0 taken, and table[0x020]=00 with upd1 not-taken, same cycle -> wr0_data=11 and wr1_data=00, both wen=1.
- Same-cycle same addr 0x055 (=01), both taken -> wr0_wen=0, wr1_wen=1, wr1_data=11.
- Back-to-back: upd0 taken at 0x0AA (=01) in cycles N and N+1 -> writes 10 then 11 (forwarding from S2); table ends at 11.
- flush asserted while S1 holds an update -> that update is never written; init_busy=1 for 2048 cycles; table is all 01 afterwards.

Source files
------------

// File: rtl/anticipator_update_pkg.sv
// Shared constants and types for the anticipator table writer:
// table geometry, 2-bit counter encoding and the writer FSM states.
package anticipator_update_pkg;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 2;

  localparam logic [CNT_W-1:0] CNT_SNT = 2'b00;
  localparam logic [CNT_W-1:0] CNT_WNT = 2'b01;
  localparam logic [CNT_W-1:0] CNT_WT  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ST  = 2'b11;

  localparam logic [CNT_W-1:0] INIT_VAL = CNT_WNT;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/anticipator_sat_cnt.sv
// Combinational 2-bit saturating counter step: taken moves toward
// strong-taken, not-taken toward strong-not-taken, clamped at both ends.
module anticipator_sat_cnt
  import anticipator_update_pkg::*;
(
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CNT_ST) cnt_o = cnt_i + CNT_W'(1);
    end else begin
      if (cnt_i != CNT_SNT) cnt_o = cnt_i - CNT_W'(1);
    end
  end

endmodule

// File: rtl/anticipator_update.sv
// Writer side of the anticipator table: sweeps the table to INIT_VAL after
// reset/flush, then runs a 2-stage read-modify-write pipeline for two lanes.
module anticipator_update #(
  parameter int                ADDR_W   = anticipator_update_pkg::ADDR_W,
  parameter int                CNT_W    = anticipator_update_pkg::CNT_W,
  parameter logic [CNT_W-1:0]  INIT_VAL = anticipator_update_pkg::INIT_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              upd0_en,
  input  logic [ADDR_W-1:0] upd0_addr,
  input  logic              upd0_taken,
  input  logic              upd1_en,
  input  logic [ADDR_W-1:0] upd1_addr,
  input  logic              upd1_taken,
  output logic              upd_ready,
  output logic              init_busy,
  output logic [ADDR_W-1:0] rd0_addr,
  input  logic [CNT_W-1:0]  rd0_data,
  output logic [ADDR_W-1:0] rd1_addr,
  input  logic [CNT_W-1:0]  rd1_data,
  output logic [ADDR_W-1:0] wr0_addr,
  output logic [CNT_W-1:0]  wr0_data,
  output logic              wr0_wen,
  output logic [ADDR_W-1:0] wr1_addr,
  output logic [CNT_W-1:0]  wr1_data,
  output logic              wr1_wen
);

  import anticipator_update_pkg::*;

  state_e            state_q;
  logic [ADDR_W-2:0] idx_q;
  logic              upd_ready_q;
  logic              init_busy_q;

  logic              s1_v0_q, s1_v1_q;
  logic [ADDR_W-1:0] s1_addr0_q, s1_addr1_q;
  logic              s1_tk0_q, s1_tk1_q;

  logic [ADDR_W-1:0] wr0_addr_q, wr1_addr_q;
  logic [CNT_W-1:0]  wr0_data_q, wr1_data_q;
  logic              wr0_wen_q, wr1_wen_q;

  logic [ADDR_W-1:0] wr0_addr_d, wr1_addr_d;
  logic [CNT_W-1:0]  wr0_data_d, wr1_data_d;
  logic              wr0_wen_d, wr1_wen_d;

  logic [CNT_W-1:0]  old0, old1;
  logic [CNT_W-1:0]  new0, new1, new1_chain;
  logic              same_addr;

  assign rd0_addr = s1_addr0_q;
  assign rd1_addr = s1_addr1_q;

  // The table only commits S2 at the next edge, so an S1 lane that hits a
  // pending S2 write must take the S2 data; port 1 is younger and wins.
  always_comb begin
    old0 = rd0_data;
    if (wr0_wen_q && (wr0_addr_q == s1_addr0_q)) old0 = wr0_data_q;
    if (wr1_wen_q && (wr1_addr_q == s1_addr0_q)) old0 = wr1_data_q;
    old1 = rd1_data;
    if (wr0_wen_q && (wr0_addr_q == s1_addr1_q)) old1 = wr0_data_q;
    if (wr1_wen_q && (wr1_addr_q == s1_addr1_q)) old1 = wr1_data_q;
  end

  assign same_addr = s1_v0_q && s1_v1_q && (s1_addr0_q == s1_addr1_q);

  anticipator_sat_cnt u_lane0 (
    .cnt_i   (old0),
    .taken_i (s1_tk0_q),
    .cnt_o   (new0)
  );

  anticipator_sat_cnt u_lane1 (
    .cnt_i   (old1),
    .taken_i (s1_tk1_q),
    .cnt_o   (new1)
  );

  anticipator_sat_cnt u_lane1_chain (
    .cnt_i   (new0),
    .taken_i (s1_tk1_q),
    .cnt_o   (new1_chain)
  );

  // Same-address pair collapses into a single port-1 write of the chained result.
  always_comb begin
    wr0_addr_d = s1_addr0_q;
    wr0_data_d = new0;
    wr0_wen_d  = s1_v0_q && !same_addr;
    wr1_addr_d = s1_addr1_q;
    wr1_data_d = same_addr ? new1_chain : new1;
    wr1_wen_d  = s1_v1_q;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= INIT;
      idx_q       <= '0;
      upd_ready_q <= 1'b0;
      init_busy_q <= 1'b1;
      s1_v0_q     <= 1'b0;
      s1_v1_q     <= 1'b0;
      s1_addr0_q  <= '0;
      s1_addr1_q  <= '0;
      s1_tk0_q    <= 1'b0;
      s1_tk1_q    <= 1'b0;
      wr0_addr_q  <= '0;
      wr0_data_q  <= '0;
      wr0_wen_q   <= 1'b0;
      wr1_addr_q  <= '0;
      wr1_data_q  <= '0;
      wr1_wen_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          wr0_addr_q <= {idx_q, 1'b0};
          wr1_addr_q <= {idx_q, 1'b1};
          wr0_data_q <= INIT_VAL;
          wr1_data_q <= INIT_VAL;
          wr0_wen_q  <= 1'b1;
          wr1_wen_q  <= 1'b1;
          s1_v0_q    <= 1'b0;
          s1_v1_q    <= 1'b0;
          idx_q      <= idx_q + 1'b1;
          if (idx_q == '1) begin
            state_q     <= RUN;
            upd_ready_q <= 1'b1;
            init_busy_q <= 1'b0;
          end
        end
        RUN: begin
          s1_v0_q    <= upd0_en;
          s1_v1_q    <= upd1_en;
          s1_addr0_q <= upd0_addr;
          s1_addr1_q <= upd1_addr;
          s1_tk0_q   <= upd0_taken;
          s1_tk1_q   <= upd1_taken;
          wr0_addr_q <= wr0_addr_d;
          wr0_data_q <= wr0_data_d;
          wr0_wen_q  <= wr0_wen_d;
          wr1_addr_q <= wr1_addr_d;
          wr1_data_q <= wr1_data_d;
          wr1_wen_q  <= wr1_wen_d;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign upd_ready = upd_ready_q;
  assign init_busy = init_busy_q;
  assign wr0_addr  = wr0_addr_q;
  assign wr0_data  = wr0_data_q;
  assign wr0_wen   = wr0_wen_q;
  assign wr1_addr  = wr1_addr_q;
  assign wr1_data  = wr1_data_q;
  assign wr1_wen   = wr1_wen_q;

endmodule

// File: tb/tb_anticipator_update.sv
// Directed bench for anticipator_update with a behavioural 4096x2 table
// that commits both write ports at the clock edge.
module tb_anticipator_update;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        upd0_en, upd1_en;
  logic [11:0] upd0_addr, upd1_addr;
  logic        upd0_taken, upd1_taken;
  logic        upd_ready, init_busy;
  logic [11:0] rd0_addr, rd1_addr;
  logic [1:0]  rd0_data, rd1_data;
  logic [11:0] wr0_addr, wr1_addr;
  logic [1:0]  wr0_data, wr1_data;
  logic        wr0_wen, wr1_wen;

  logic [1:0]  mem [0:4095];
  logic        preEn;
  logic [11:0] preAddr;
  logic [1:0]  preData;

  int cmpCount  = 0;
  int failCount = 0;

  anticipator_update dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .upd0_en    (upd0_en),
    .upd0_addr  (upd0_addr),
    .upd0_taken (upd0_taken),
    .upd1_en    (upd1_en),
    .upd1_addr  (upd1_addr),
    .upd1_taken (upd1_taken),
    .upd_ready  (upd_ready),
    .init_busy  (init_busy),
    .rd0_addr   (rd0_addr),
    .rd0_data   (rd0_data),
    .rd1_addr   (rd1_addr),
    .rd1_data   (rd1_data),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr0_wen    (wr0_wen),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .wr1_wen    (wr1_wen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Table model: combinational read, commit on the clock edge.
  assign rd0_data = mem[rd0_addr];
  assign rd1_data = mem[rd1_addr];

  always @(posedge clk) begin
    if (preEn)   mem[preAddr]  <= preData;
    if (wr0_wen) mem[wr0_addr] <= wr0_data;
    if (wr1_wen) mem[wr1_addr] <= wr1_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [1:0] d);
    preEn = 1'b1; preAddr = a; preData = d;
    step();
    preEn = 1'b0;
  endtask

  // Walks the init sweep from the first busy cycle; counts busy cycles and
  // any cycle whose write pair is not the expected {idx,0}/{idx,1} with 01.
  task automatic run_sweep(output int busy, output int seqErr);
    int k;
    busy = 0; seqErr = 0; k = 0;
    while (init_busy === 1'b1 && k < 3000) begin
      busy++;
      step();
      if (!(wr0_wen === 1'b1 && wr0_addr === 12'(2*k) && wr0_data === 2'b01 &&
            wr1_wen === 1'b1 && wr1_addr === 12'(2*k+1) && wr1_data === 2'b01))
        seqErr++;
      k++;
      if (init_busy !== 1'b1) upd0_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; preEn = 1'b0;
    upd0_en = 0; upd0_addr = '0; upd0_taken = 0;
    upd1_en = 0; upd1_addr = '0; upd1_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    cmpCount++;
    if ({init_busy, upd_ready, wr0_wen, wr1_wen} !== 4'b1000) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got busy/ready/wen0/wen1=%b required 1000",
               {init_busy, upd_ready, wr0_wen, wr1_wen});
    end
    cmpCount++;
    if ({wr0_addr, wr0_data, wr1_addr, wr1_data} !== 28'd0) begin
      failCount++;
      $display("[TB] FAIL reset_wr_regs: got %h required 0",
               {wr0_addr, wr0_data, wr1_addr, wr1_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_init_sweep();
    int busy, seqErr, bad;
    run_sweep(busy, seqErr);
    cmpCount++;
    if (busy !== 2048) begin
      failCount++;
      $display("[TB] FAIL init_busy_cycles: got %0d required 2048", busy);
    end
    cmpCount++;
    if (seqErr !== 0) begin
      failCount++;
      $display("[TB] FAIL init_write_seq: got %0d bad cycles required 0", seqErr);
    end
    cmpCount++;
    if (upd_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL init_ready: got %b required 1", upd_ready);
    end
    step();
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== 2'b01) bad++;
    cmpCount++;
    if (bad !== 0) begin
      failCount++;
      $display("[TB] FAIL init_table: got %0d entries not 01 required 0", bad);
    end
  endtask

  task automatic test_single_update();
    upd0_en = 1; upd0_addr = 12'h123; upd0_taken = 1;
    step();
    upd0_en = 0;
    step();
    cmpCount++;
    if ({wr0_wen, wr0_addr, wr0_data, wr1_wen} !== {1'b1, 12'h123, 2'b10, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL single_upd: got wen0=%b addr0=%h data0=%b wen1=%b required 1 123 10 0",
               wr0_wen, wr0_addr, wr0_data, wr1_wen);
    end
    step();
  endtask

  task automatic test_saturation();
    preload(12'h010, 2'b11);
    preload(12'h020, 2'b00);
    upd0_en = 1; upd0_addr = 12'h010; upd0_taken = 1;
    upd1_en = 1; upd1_addr = 12'h020; upd1_taken = 0;
    step();
    upd0_en = 0; upd1_en = 0;
    step();
    cmpCount++;
    if ({wr0_wen, wr0_addr, wr0_data} !== {1'b1, 12'h010, 2'b11}) begin
      failCount++;
      $display("[TB] FAIL sat_high: got wen0=%b addr0=%h data0=%b required 1 010 11",
               wr0_wen, wr0_addr, wr0_data);
    end
    cmpCount++;
    if ({wr1_wen, wr1_addr, wr1_data} !== {1'b1, 12'h020, 2'b00}) begin
      failCount++;
      $display("[TB] FAIL sat_low: got wen1=%b addr1=%h data1=%b required 1 020 00",
               wr1_wen, wr1_addr, wr1_data);
    end
    step();
  endtask

  task automatic test_same_addr();
    upd0_en = 1; upd0_addr = 12'h055; upd0_taken = 1;
    upd1_en = 1; upd1_addr = 12'h055; upd1_taken = 1;
    step();
    upd0_en = 0; upd1_en = 0;
    step();
    cmpCount++;
    if ({wr0_wen, wr1_wen, wr1_addr, wr1_data} !== {1'b0, 1'b1, 12'h055, 2'b11}) begin
      failCount++;
      $display("[TB] FAIL same_addr: got wen0=%b wen1=%b addr1=%h data1=%b required 0 1 055 11",
               wr0_wen, wr1_wen, wr1_addr, wr1_data);
    end
    step();
    cmpCount++;
    if (mem[12'h055] !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL same_addr_table: got %b required 11", mem[12'h055]);
    end
  endtask

  task automatic test_back_to_back();
    upd0_en = 1; upd0_addr = 12'h0AA; upd0_taken = 1;
    step();
    step();
    upd0_en = 0;
    cmpCount++;
    if ({wr0_wen, wr0_addr, wr0_data} !== {1'b1, 12'h0AA, 2'b10}) begin
      failCount++;
      $display("[TB] FAIL b2b_first: got wen0=%b addr0=%h data0=%b required 1 0aa 10",
               wr0_wen, wr0_addr, wr0_data);
    end
    step();
    cmpCount++;
    if ({wr0_wen, wr0_addr, wr0_data} !== {1'b1, 12'h0AA, 2'b11}) begin
      failCount++;
      $display("[TB] FAIL b2b_second: got wen0=%b addr0=%h data0=%b required 1 0aa 11",
               wr0_wen, wr0_addr, wr0_data);
    end
    step();
    cmpCount++;
    if (mem[12'h0AA] !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL b2b_table: got %b required 11", mem[12'h0AA]);
    end
  endtask

  task automatic test_flush();
    int busy, seqErr, bad;
    upd0_en = 1; upd0_addr = 12'h123; upd0_taken = 1;
    step();
    upd0_en = 0; flush = 1;
    step();
    flush = 0;
    cmpCount++;
    if ({wr0_wen, wr1_wen, init_busy, upd_ready} !== 4'b0010) begin
      failCount++;
      $display("[TB] FAIL flush_squash: got wen0/wen1/busy/ready=%b required 0010",
               {wr0_wen, wr1_wen, init_busy, upd_ready});
    end
    // Updates presented during the sweep must be ignored.
    upd0_en = 1; upd0_addr = 12'h300; upd0_taken = 1;
    run_sweep(busy, seqErr);
    upd0_en = 0;
    cmpCount++;
    if (busy !== 2048) begin
      failCount++;
      $display("[TB] FAIL flush_busy_cycles: got %0d required 2048", busy);
    end
    cmpCount++;
    if (seqErr !== 0) begin
      failCount++;
      $display("[TB] FAIL flush_write_seq: got %0d bad cycles required 0", seqErr);
    end
    step();
    step();
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== 2'b01) bad++;
    cmpCount++;
    if (bad !== 0) begin
      failCount++;
      $display("[TB] FAIL flush_table: got %0d entries not 01 required 0", bad);
    end
    cmpCount++;
    if ({upd_ready, init_busy, wr0_wen, wr1_wen} !== 4'b1000) begin
      failCount++;
      $display("[TB] FAIL flush_run_idle: got ready/busy/wen0/wen1=%b required 1000",
               {upd_ready, init_busy, wr0_wen, wr1_wen});
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_single_update();
    test_saturation();
    test_same_addr();
    test_back_to_back();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
